tag_engine: RTL and testbench

TAG_ENGINE -- requirements
Module: tag_engine

---
 rtl/tag_engine.sv | 133 +++++++++++++
 tb/tb_tag_engine.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tag_engine.sv
// tag_engine: time-tags synchronised detector edges into a record FIFO and streams records LSB-byte first.
// Optional TAG_WRAP_MARKER_EN writes a marker record whenever the running timestamp wraps.
module tag_engine #(
  parameter int NUM_DET    = 4,
  parameter int TS_WIDTH   = 36,
  parameter int LASER_W    = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_DET-1:0]                  detectors,
  input  logic [(LASER_W>0?LASER_W:1)-1:0]    laser_en,
  input  logic                                start_det,
  input  logic                                stop_det,
  input  logic                                reset_counter,
  output logic                                running,
  output logic                                data_avail,
  output logic [7:0]                          data,
  input  logic                                data_ack,
  input  logic                                request_length,
  output logic [15:0]                         length,
  output logic [15:0]                         dropped
);
  localparam int REC_W = 8*((LASER_W+NUM_DET+TS_WIDTH+7)/8);
  localparam int NB    = REC_W/8;
  localparam int IW    = $clog2(NB);
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [NUM_DET-1:0]  r_s1, r_s2, r_prev;
  logic [1:0]          r_arm;
  logic [TS_WIDTH-1:0] r_ts;
  logic                r_running;
  logic [AW:0]         r_wr_ptr, r_rd_ptr;
  logic [REC_W-1:0]    r_mem [FIFO_DEPTH];
  logic [15:0]         r_cnt, r_length, r_dropped;
  state_t              r_state, w_next;
  logic [IW-1:0]       r_idx, w_idx_next;
  logic                w_pop;

  logic [NUM_DET-1:0]  w_edge, w_rec_edge;
  logic [TS_WIDTH-1:0] w_rec_ts;
  logic [REC_W-1:0]    w_rec, w_head;
  logic                w_hit, w_wrap, w_full, w_empty, w_push, w_more;
  logic [1:0]          w_ndrop;
  logic [16:0]         w_dsum;
  logic [AW:0]         w_cnt;

  // Edges stay masked until the synchroniser has settled after reset, so inputs already high are not seen as edges.
  assign w_edge = r_s2 & ~r_prev & {NUM_DET{&r_arm}};
  assign w_hit  = r_running & |w_edge;
`ifdef TAG_WRAP_MARKER_EN
  assign w_wrap = r_running & ~reset_counter & &r_ts;
`else
  assign w_wrap = 1'b0;
`endif
  assign w_cnt      = r_wr_ptr - r_rd_ptr;
  assign w_empty    = r_wr_ptr == r_rd_ptr;
  assign w_full     = w_cnt == (AW+1)'(FIFO_DEPTH);
  assign w_more     = w_cnt != (AW+1)'(1);
  assign w_push     = (w_hit | w_wrap) & ~w_full;
  assign w_ndrop    = {1'b0, w_hit & (w_wrap | w_full)} + {1'b0, w_wrap & w_full};
  assign w_dsum     = {1'b0, r_dropped} + 17'(w_ndrop);
  assign w_rec_edge = w_wrap ? '0 : w_edge;
  assign w_rec_ts   = w_wrap ? '0 : r_ts;

  generate
    if (LASER_W > 0) begin : g_laser
      assign w_rec = REC_W'({laser_en, w_rec_edge, w_rec_ts});
    end else begin : g_nolaser
      assign w_rec = REC_W'({w_rec_edge, w_rec_ts});
    end
  endgenerate

  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign running    = r_running;
  assign data_avail = r_state == SHIFT;
  assign data       = (r_state == SHIFT) ? w_head[{r_idx, 3'b000} +: 8] : 8'h00;
  assign length     = r_length;
  assign dropped    = r_dropped;

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_rec;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_prev    <= '0;
      r_arm     <= '0;
      r_ts      <= '0;
      r_running <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_length  <= '0;
      r_dropped <= '0;
      r_state   <= IDLE;
      r_idx     <= '0;
    end else begin
      r_s1      <= detectors;
      r_s2      <= r_s1;
      r_prev    <= r_s2;
      r_arm     <= &r_arm ? r_arm : r_arm + 2'd1;
      r_ts      <= reset_counter ? '0 : r_running ? r_ts + 1'b1 : r_ts;
      r_running <= stop_det ? 1'b0 : start_det ? 1'b1 : r_running;
      r_wr_ptr  <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
      r_rd_ptr  <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
      r_dropped <= w_dsum[16] ? 16'hFFFF : w_dsum[15:0];
      if (request_length) begin
        r_length <= r_cnt;
        r_cnt    <= {15'd0, w_push};
      end else if (w_push && !(&r_cnt)) r_cnt <= r_cnt + 16'd1;
      r_state   <= w_next;
      r_idx     <= w_idx_next;
    end

  // The head record is read in place and only popped after its last byte is acked.
  always_comb begin
    w_next     = r_state;
    w_idx_next = r_idx;
    w_pop      = 1'b0;
    if (r_state == IDLE) begin
      w_next     = w_empty ? IDLE : SHIFT;
      w_idx_next = '0;
    end else if (data_ack) begin
      w_pop      = r_idx == IW'(NB-1);
      w_idx_next = w_pop ? '0 : r_idx + 1'b1;
      w_next     = (w_pop && !w_more) ? IDLE : SHIFT;
    end
  end
endmodule

// File: tb/tb_tag_engine.sv
// tb_tag_engine: directed scoreboard bench for tag_engine (default instance plus a small-FIFO, 16-bit timestamp instance).
module tb_tag_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n0, start0, stop0, rc0, ack0, req0, run0, avail0;
  logic [3:0] det0, laser0;
  logic [7:0] data0;
  logic [15:0] len0, drop0;

  logic       rst_n1, start1, stop1, rc1, ack1, req1, run1, avail1;
  logic [3:0] det1, laser1;
  logic [7:0] data1;
  logic [15:0] len1, drop1;

  tag_engine dut0 (
    .clk(clk), .rst_n(rst_n0), .detectors(det0), .laser_en(laser0),
    .start_det(start0), .stop_det(stop0), .reset_counter(rc0),
    .running(run0), .data_avail(avail0), .data(data0), .data_ack(ack0),
    .request_length(req0), .length(len0), .dropped(drop0));

  tag_engine #(.NUM_DET(4), .TS_WIDTH(16), .LASER_W(4), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n1), .detectors(det1), .laser_en(laser1),
    .start_det(start1), .stop_det(stop1), .reset_counter(rc1),
    .running(run1), .data_avail(avail1), .data(data1), .data_ack(ack1),
    .request_length(req1), .length(len1), .dropped(drop1));

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rec(input logic [47:0] r);
    for (int i = 0; i < 6; i++) sb.push_back(r[i*8 +: 8]);
  endtask

  // Clears the timestamp, waits t cycles, then pulses d for one cycle; the record carries timestamp t+2.
  task automatic pulse_at(input logic [3:0] d, input int t, input logic req);
    rc0 = 1'b1;
    tick();
    rc0 = 1'b0;
    repeat (t) tick();
    det0 = d;
    tick();
    det0 = 4'h0;
    tick();
    req0 = req;
    tick();
    req0 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
    chk("drain_left", 16'(sb.size()), 16'd0);
  endtask

  always @(negedge clk)
    if (rst_n0 && avail0 && ack0) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_byte: got %0h expected none", data0);
      end else chk("byte", {8'h00, data0}, {8'h00, sb.pop_front()});
    end

  initial begin
    rst_n0 = 1'b0; start0 = 0; stop0 = 0; rc0 = 0; ack0 = 0; req0 = 0; det0 = 0; laser0 = 4'hA;
    rst_n1 = 1'b0; start1 = 0; stop1 = 0; rc1 = 0; ack1 = 0; req1 = 0; det1 = 0; laser1 = 4'h6;
    repeat (3) tick();
    chk("rst_running", {15'd0, run0}, 16'd0);
    chk("rst_avail", {15'd0, avail0}, 16'd0);
    chk("rst_data", {8'h00, data0}, 16'd0);
    chk("rst_length", len0, 16'd0);
    chk("rst_dropped", drop0, 16'd0);
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;
    repeat (3) tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("running_set", {15'd0, run0}, 16'd1);

    push_rec(48'h0A20_0000_0005);
    pulse_at(4'b0010, 3, 1'b0);
    tick();
    chk("hold_avail", {15'd0, avail0}, 16'd1);
    chk("hold_data", {8'h00, data0}, 16'h05);
    repeat (3) tick();
    chk("hold_data2", {8'h00, data0}, 16'h05);
    ack0 = 1'b1;

    push_rec(48'h0A50_0000_0002);
    pulse_at(4'b0101, 0, 1'b0);
    push_rec(48'h0A80_0000_0003);
    pulse_at(4'b1000, 1, 1'b1);
    chk("len_prior", len0, 16'd2);
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    chk("len_one", len0, 16'd1);
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    chk("len_zero", len0, 16'd0);

    laser0 = 4'h3;
    push_rec(48'h03F0_0000_0006);
    pulse_at(4'b1111, 4, 1'b0);
    drain();

    start0 = 1'b1;
    stop0 = 1'b1;
    tick();
    start0 = 1'b0;
    stop0 = 1'b0;
    chk("stop_wins", {15'd0, run0}, 16'd0);
    pulse_at(4'b0001, 0, 1'b0);
    repeat (10) tick();
    chk("idle_no_rec", {15'd0, avail0}, 16'd0);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;

    ack0 = 1'b0;
    push_rec(48'h0310_0000_0002);
    pulse_at(4'b0001, 0, 1'b0);
    push_rec(48'h0320_0000_0002);
    pulse_at(4'b0010, 0, 1'b0);
    ack0 = 1'b1;
    tick();
    tick();
    ack0 = 1'b0;
    chk("mid_avail", {15'd0, avail0}, 16'd1);
    chk("mid_sb", 16'(sb.size()), 16'd10);
    det0 = 4'b0110;
    rst_n0 = 1'b0;
    repeat (2) tick();
    sb.delete();
    chk("rst2_avail", {15'd0, avail0}, 16'd0);
    chk("rst2_running", {15'd0, run0}, 16'd0);
    rst_n0 = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    ack0 = 1'b1;
    repeat (10) tick();
    chk("no_spurious", {15'd0, avail0}, 16'd0);
    chk("rst2_dropped", drop0, 16'd0);
    det0 = 4'h0;
    repeat (3) tick();
    push_rec(48'h0340_0000_0002);
    pulse_at(4'b0100, 0, 1'b0);
    drain();

    start1 = 1'b1;
    rc1 = 1'b1;
    tick();
    start1 = 1'b0;
    rc1 = 1'b0;
    repeat (6) begin
      det1 = 4'b0001;
      tick();
      det1 = 4'b0000;
      tick();
      tick();
    end
    repeat (5) tick();
    chk("full_avail", {15'd0, avail1}, 16'd1);
    chk("full_dropped", drop1, 16'd2);
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    chk("full_length", len1, 16'd4);
    ack1 = 1'b1;
    repeat (12) tick();
    ack1 = 1'b0;
    chk("full_drained", {15'd0, avail1}, 16'd0);

    rc1 = 1'b1;
    tick();
    rc1 = 1'b0;
    repeat (65536) tick();
    tick();
`ifdef TAG_WRAP_MARKER_EN
    chk("mark_avail", {15'd0, avail1}, 16'd1);
    chk("mark_b0", {8'h00, data1}, 16'h00);
    ack1 = 1'b1;
    tick();
    chk("mark_b1", {8'h00, data1}, 16'h00);
    tick();
    chk("mark_b2", {8'h00, data1}, 16'h60);
    tick();
    ack1 = 1'b0;
    chk("mark_done", {15'd0, avail1}, 16'd0);
`else
    chk("wrap_silent", {15'd0, avail1}, 16'd0);
`endif
    chk("wrap_dropped", drop1, 16'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
